sync_pulse_detector: RTL and testbench
======================================

Name: sync_pulse_detector

Overview:
Sits directly downstream of the moving-average filter on the digitised composite/luma path. Slices the filtered signed sample stream into a sync level using hysteresis and rejects glitches with a minimum-run qualifier. Classifies each qualified pulse as horizontal (normal) or broad (vertical), and measures pulse width and the period between consecutive sync starts. Feeds the timing generator and line-locking logic.

Parameters:
DATA_WIDTH, 12, width of signed input sample
THRESH_LOW, 200, signed; sample < THRESH_LOW is a "low" (sync-tip) sample
THRESH_HIGH, 400, signed; sample > THRESH_HIGH is a "high" sample; must be > THRESH_LOW
MIN_PULSE, 8, consecutive qualifying samples needed to enter or leave sync; must be ≥ 2
VSYNC_MIN, 600, pulse width (cycles) at or above which a pulse is broad
HSYNC_RUN, 4, consecutive normal pulses required before a broad pulse raises vsync_strobe
CNT_WIDTH, 16, width of width/period counters

Ports:
clk  in  1  clock; one sample per cycle, no valid qualifier
rst  in  1  asynchronous, active-high reset
data_in  in  DATA_WIDTH signed  filtered sample
sync_level  out  1  1 while state is IN_SYNC or QUAL_HIGH
sync_start  out  1  one-cycle strobe when a pulse qualifies
hsync_strobe  out  1  one-cycle strobe at end of a normal pulse
vsync_strobe  out  1  one-cycle strobe, first broad pulse after a normal run
pulse_width  out  CNT_WIDTH  width of the most recently ended pulse
line_period  out  CNT_WIDTH  cycles between the last two sync_start strobes
line_valid  out  1  one-cycle strobe when line_period updates

Behaviour:
- Reset clears all outputs, counters, and the normal-run count, and sets the state to VIDEO. Any partial pulse is discarded, with no strobes. No first period is reported after reset.
- All outputs are registered. A strobe asserts in the cycle after the edge that captured the deciding sample.
- Sample classes: low (< THRESH_LOW), high (> THRESH_HIGH), mid (otherwise). Compare signed at DATA_WIDTH.
- FSM states: VIDEO, QUAL_LOW, IN_SYNC, QUAL_HIGH.
  - VIDEO: on a low sample, go to QUAL_LOW with qual_cnt=1 and width_cnt=1. Otherwise stay.
  - QUAL_LOW: a low sample increments qual_cnt and width_cnt. When the MIN_PULSE-th consecutive low sample is captured, go to IN_SYNC and pulse sync_start. A high or mid sample returns to VIDEO with no strobe (glitch rejected).
  - IN_SYNC: width_cnt increments every cycle. A high sample goes to QUAL_HIGH with qual_cnt=1. Low and mid samples stay (hysteresis).
  - QUAL_HIGH: on the MIN_PULSE-th consecutive high sample, go to VIDEO and end the pulse. A low or mid sample returns to IN_SYNC. width_cnt keeps counting through QUAL_HIGH.
- Width rule: the width counts from the first low sample up to, but excluding, the first high sample of the terminating run. pulse_width loads this value at pulse end.
- Pulse end:
  - If width < VSYNC_MIN: pulse hsync_strobe; normal_run increments, saturating at HSYNC_RUN.
  - Otherwise: no hsync_strobe; normal_run clears.
- Broad detection happens in IN_SYNC/QUAL_HIGH on the cycle width_cnt reaches VSYNC_MIN. If normal_run ≥ HSYNC_RUN, pulse vsync_strobe. This happens at most once per pulse.
- Period counter:
  - Counts cycles since the last sync_start and saturates at 2^CNT_WIDTH−1.
  - On sync_start it loads line_period with the distance between starts and pulses line_valid, but only if a prior start exists since reset.
  - The counter then restarts so that pulses every N cycles report exactly N.
- width_cnt saturates at 2^CNT_WIDTH−1 and never wraps.
- Broad pulses and serrations also produce sync_start and period updates. Classification is left to downstream logic.

Test Plan:
(Bench parameters: MIN_PULSE=4, VSYNC_MIN=20, HSYNC_RUN=4, thresholds 200/400; idle level 1000, sync tip 0.)
1. Assert rst mid-pulse (after 6 low samples), release, drive 1000 → every output is 0 throughout; no hsync_strobe appears after release.
2. Drive 3×0 then 1000 → sync_start never asserts and sync_level stays 0.
3. Drive 10×0 then 4×1000 → sync_start asserts 1 cycle after the 4th zero. hsync_strobe asserts 1 cycle after the 4th 1000, with pulse_width=10.
4. Drive 10-cycle pulses starting every 100 cycles, for 3 pulses → no line_valid on the first start; line_valid on the 2nd and 3rd starts with line_period=100.
5. Drive 4 normal pulses, then a 30-cycle pulse → vsync_strobe once, 1 cycle after width reaches 20; no hsync_strobe for the broad pulse; pulse_width=30. A second 30-cycle pulse yields no vsync_strobe.
6. Hysteresis: inside a pulse, drive 2×1000, then 300, then 5×0, then 4×1000 → no early exit; pulse_width counts through the bounce (2+1+5 cycles added to the width).

Source files
------------

// File: rtl/sync_pulse_detector.sv
// Sync slicer for the filtered luma path: hysteresis plus minimum-run qualification,
// normal/broad pulse classification, and pulse width / line period measurement.
module sync_pulse_detector #(
    parameter int DATA_WIDTH  = 12,
    parameter int THRESH_LOW  = 200,
    parameter int THRESH_HIGH = 400,
    parameter int MIN_PULSE   = 8,
    parameter int VSYNC_MIN   = 600,
    parameter int HSYNC_RUN   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         sync_level,
    output logic                         sync_start,
    output logic                         hsync_strobe,
    output logic                         vsync_strobe,
    output logic [CNT_WIDTH-1:0]         pulse_width,
    output logic [CNT_WIDTH-1:0]         line_period,
    output logic                         line_valid
);

    localparam int QW = $clog2(MIN_PULSE + 1);
    localparam int RW = (HSYNC_RUN < 1) ? 1 : $clog2(HSYNC_RUN + 1);

    localparam logic signed [DATA_WIDTH-1:0] T_LOW   = DATA_WIDTH'(THRESH_LOW);
    localparam logic signed [DATA_WIDTH-1:0] T_HIGH  = DATA_WIDTH'(THRESH_HIGH);
    localparam logic [QW-1:0]                Q_ZERO  = {QW{1'b0}};
    localparam logic [QW-1:0]                Q_ONE   = QW'(1'b1);
    localparam logic [QW-1:0]                Q_MIN   = QW'(MIN_PULSE);
    localparam logic [RW-1:0]                R_ZERO  = {RW{1'b0}};
    localparam logic [RW-1:0]                R_ONE   = RW'(1'b1);
    localparam logic [RW-1:0]                R_MAX   = RW'(HSYNC_RUN);
    localparam logic [CNT_WIDTH-1:0]         C_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]         C_ONE   = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0]         C_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]         C_VSYNC = CNT_WIDTH'(VSYNC_MIN);

    typedef enum logic [1:0] {
        VIDEO     = 2'd0,
        QUAL_LOW  = 2'd1,
        IN_SYNC   = 2'd2,
        QUAL_HIGH = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [QW-1:0]        qual_cnt_r, qual_cnt_s, qual_inc_s;
    logic [CNT_WIDTH-1:0] width_cnt_r, width_cnt_s, width_inc_s;
    logic [CNT_WIDTH-1:0] width_mark_r, width_mark_s;
    logic [RW-1:0]        normal_run_r, normal_run_s;
    logic                 broad_seen_r, broad_seen_s;
    logic [CNT_WIDTH-1:0] period_cnt_r, period_cnt_s;
    logic                 have_start_r, have_start_s;

    logic                 sync_level_r, sync_level_s;
    logic                 sync_start_r, sync_start_s;
    logic                 hsync_r, hsync_s;
    logic                 vsync_r, vsync_s;
    logic [CNT_WIDTH-1:0] pulse_width_r, pulse_width_s;
    logic [CNT_WIDTH-1:0] line_period_r, line_period_s;
    logic                 line_valid_r, line_valid_s;

    logic                 is_low_s, is_high_s, broad_hit_s;

    assign is_low_s    = (data_in < T_LOW);
    assign is_high_s   = (data_in > T_HIGH);
    assign qual_inc_s  = qual_cnt_r + Q_ONE;
    assign width_inc_s = (width_cnt_r == C_MAX) ? C_MAX : (width_cnt_r + C_ONE);
    // Broad detection fires once per pulse, the first time the running width reaches VSYNC_MIN.
    assign broad_hit_s = ((state_r == IN_SYNC) || (state_r == QUAL_HIGH)) &&
                         !broad_seen_r && (width_inc_s >= C_VSYNC);

    // Next-state, counter and strobe decode from the current state and sample class.
    always_comb begin
        state_s       = state_r;
        qual_cnt_s    = qual_cnt_r;
        width_cnt_s   = width_cnt_r;
        width_mark_s  = width_mark_r;
        normal_run_s  = normal_run_r;
        broad_seen_s  = broad_seen_r;
        period_cnt_s  = period_cnt_r;
        have_start_s  = have_start_r;
        sync_start_s  = 1'b0;
        hsync_s       = 1'b0;
        vsync_s       = 1'b0;
        pulse_width_s = pulse_width_r;
        line_period_s = line_period_r;
        line_valid_s  = 1'b0;

        case (state_r)
            VIDEO: begin
                if (is_low_s) begin
                    state_s      = QUAL_LOW;
                    qual_cnt_s   = Q_ONE;
                    width_cnt_s  = C_ONE;
                    broad_seen_s = 1'b0;
                end else begin
                    state_s = VIDEO;
                end
            end
            QUAL_LOW: begin
                if (is_low_s) begin
                    width_cnt_s = width_inc_s;
                    if (qual_inc_s == Q_MIN) begin
                        state_s      = IN_SYNC;
                        qual_cnt_s   = Q_ZERO;
                        sync_start_s = 1'b1;
                    end else begin
                        qual_cnt_s = qual_inc_s;
                    end
                end else begin
                    // Too short to be sync: drop the partial pulse silently.
                    state_s     = VIDEO;
                    qual_cnt_s  = Q_ZERO;
                    width_cnt_s = C_ZERO;
                end
            end
            IN_SYNC: begin
                width_cnt_s = width_inc_s;
                if (is_high_s) begin
                    state_s      = QUAL_HIGH;
                    qual_cnt_s   = Q_ONE;
                    width_mark_s = width_cnt_r;
                end else begin
                    state_s = IN_SYNC;
                end
            end
            QUAL_HIGH: begin
                width_cnt_s = width_inc_s;
                if (is_high_s) begin
                    if (qual_inc_s == Q_MIN) begin
                        // Width excludes the terminating high run, so report the mark.
                        state_s       = VIDEO;
                        qual_cnt_s    = Q_ZERO;
                        width_cnt_s   = C_ZERO;
                        pulse_width_s = width_mark_r;
                        if (width_mark_r < C_VSYNC) begin
                            hsync_s      = 1'b1;
                            normal_run_s = (normal_run_r >= R_MAX) ? R_MAX : (normal_run_r + R_ONE);
                        end else begin
                            normal_run_s = R_ZERO;
                        end
                    end else begin
                        qual_cnt_s = qual_inc_s;
                    end
                end else begin
                    state_s    = IN_SYNC;
                    qual_cnt_s = Q_ZERO;
                end
            end
            default: begin
                state_s     = VIDEO;
                qual_cnt_s  = Q_ZERO;
                width_cnt_s = C_ZERO;
            end
        endcase

        if (broad_hit_s) begin
            broad_seen_s = 1'b1;
            vsync_s      = (normal_run_r >= R_MAX);
        end else begin
            vsync_s = 1'b0;
        end

        // Period restarts at 1 on each start so starts N cycles apart report N.
        if (sync_start_s) begin
            period_cnt_s = C_ONE;
            have_start_s = 1'b1;
            if (have_start_r) begin
                line_period_s = period_cnt_r;
                line_valid_s  = 1'b1;
            end else begin
                line_valid_s = 1'b0;
            end
        end else begin
            period_cnt_s = (period_cnt_r == C_MAX) ? C_MAX : (period_cnt_r + C_ONE);
        end

        sync_level_s = (state_s == IN_SYNC) || (state_s == QUAL_HIGH);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= VIDEO;
            qual_cnt_r    <= Q_ZERO;
            width_cnt_r   <= C_ZERO;
            width_mark_r  <= C_ZERO;
            normal_run_r  <= R_ZERO;
            broad_seen_r  <= 1'b0;
            period_cnt_r  <= C_ZERO;
            have_start_r  <= 1'b0;
            sync_level_r  <= 1'b0;
            sync_start_r  <= 1'b0;
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            pulse_width_r <= C_ZERO;
            line_period_r <= C_ZERO;
            line_valid_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            qual_cnt_r    <= qual_cnt_s;
            width_cnt_r   <= width_cnt_s;
            width_mark_r  <= width_mark_s;
            normal_run_r  <= normal_run_s;
            broad_seen_r  <= broad_seen_s;
            period_cnt_r  <= period_cnt_s;
            have_start_r  <= have_start_s;
            sync_level_r  <= sync_level_s;
            sync_start_r  <= sync_start_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            pulse_width_r <= pulse_width_s;
            line_period_r <= line_period_s;
            line_valid_r  <= line_valid_s;
        end
    end

    assign sync_level   = sync_level_r;
    assign sync_start   = sync_start_r;
    assign hsync_strobe = hsync_r;
    assign vsync_strobe = vsync_r;
    assign pulse_width  = pulse_width_r;
    assign line_period  = line_period_r;
    assign line_valid   = line_valid_r;

endmodule

// File: tb/tb_sync_pulse_detector.sv
// Scoreboard bench for sync_pulse_detector: expected strobes are queued with the
// sample index at which they must appear and popped as the DUT raises them.
module tb_sync_pulse_detector;

    localparam int MIN_P   = 4;
    localparam int VSYNC_M = 20;
    localparam int HRUN    = 4;
    localparam int IDLE    = 1000;
    localparam int TIP     = 0;

    localparam int K_START = 1;
    localparam int K_LINE  = 2;
    localparam int K_HSYNC = 3;
    localparam int K_VSYNC = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [11:0] data_in;
    logic               sync_level, sync_start, hsync_strobe, vsync_strobe, line_valid;
    logic [15:0]        pulse_width, line_period;

    typedef struct {
        int kind;
        int at;
        int val;
    } ev_t;

    ev_t q[$];
    int  samp       = 0;
    int  errors     = 0;
    int  checks     = 0;
    int  have_start = 0;
    int  last_start = 0;
    int  run        = 0;

    sync_pulse_detector #(
        .DATA_WIDTH (12),
        .THRESH_LOW (200),
        .THRESH_HIGH(400),
        .MIN_PULSE  (MIN_P),
        .VSYNC_MIN  (VSYNC_M),
        .HSYNC_RUN  (HRUN),
        .CNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .sync_level  (sync_level),
        .sync_start  (sync_start),
        .hsync_strobe(hsync_strobe),
        .vsync_strobe(vsync_strobe),
        .pulse_width (pulse_width),
        .line_period (line_period),
        .line_valid  (line_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (sample %0d)", tag, obs, exp, samp);
        end
    endtask

    task automatic push(input int kind, input int at, input int val);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            check_eq("unexpected_event_kind", kind, 0);
        end else begin
            e = q.pop_front();
            check_eq("event_kind", kind, e.kind);
            check_eq("event_time", samp, e.at);
            if (kind == K_LINE)       check_eq("line_period", {16'd0, line_period}, e.val);
            else if (kind == K_HSYNC) check_eq("pulse_width", {16'd0, pulse_width}, e.val);
        end
    endtask

    task automatic observe();
        while (q.size() > 0 && q[0].at < samp) begin
            check_eq("missed_event_kind", 0, q[0].kind);
            void'(q.pop_front());
        end
        if (sync_start)   take(K_START);
        if (line_valid)   take(K_LINE);
        if (hsync_strobe) take(K_HSYNC);
        if (vsync_strobe) take(K_VSYNC);
    endtask

    task automatic step(input int v);
        logic [31:0] w;
        w = v;
        data_in = w[11:0];
        @(posedge clk);
        #1;
        samp++;
        observe();
    endtask

    task automatic drive(input int v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        drive(TIP, n);
        rst = 1'b0;
        have_start = 0;
        run        = 0;
    endtask

    // Expectations for a single start: sync_start, plus line_valid when a prior start exists.
    task automatic expect_start(input int at);
        push(K_START, at, 0);
        if (have_start != 0) push(K_LINE, at, at - last_start);
        have_start = 1;
        last_start = at;
    endtask

    // Plain pulse of nlow tip samples followed by nhigh idle samples.
    task automatic pulse(input int nlow, input int nhigh);
        int base;
        base = samp;
        if (nlow >= MIN_P) begin
            expect_start(base + MIN_P);
            if (nlow >= VSYNC_M && run >= HRUN) push(K_VSYNC, base + VSYNC_M, 0);
            if (nhigh >= MIN_P) begin
                if (nlow < VSYNC_M) begin
                    push(K_HSYNC, base + nlow + MIN_P, nlow);
                    run = (run >= HRUN) ? HRUN : run + 1;
                end else begin
                    run = 0;
                end
            end
        end
        drive(TIP, nlow);
        drive(IDLE, nhigh);
    endtask

    initial begin
        int base;
        rst     = 1'b1;
        data_in = 12'sd1000;

        // Reset state
        drive(IDLE, 3);
        check_eq("rst_sync_level", sync_level, 0);
        check_eq("rst_sync_start", sync_start, 0);
        check_eq("rst_hsync", hsync_strobe, 0);
        check_eq("rst_vsync", vsync_strobe, 0);
        check_eq("rst_line_valid", line_valid, 0);
        check_eq("rst_pulse_width", {16'd0, pulse_width}, 0);
        check_eq("rst_line_period", {16'd0, line_period}, 0);
        rst = 1'b0;
        drive(IDLE, 5);

        // 1: reset in the middle of a qualified pulse discards it
        base = samp;
        expect_start(base + MIN_P);
        drive(TIP, 6);
        check_eq("t1_level_in_pulse", sync_level, 1);
        apply_reset(2);
        check_eq("t1_level_in_reset", sync_level, 0);
        drive(IDLE, 10);
        check_eq("t1_level_after", sync_level, 0);
        check_eq("t1_pulse_width", {16'd0, pulse_width}, 0);
        check_eq("t1_line_period", {16'd0, line_period}, 0);

        // 2: glitch shorter than MIN_PULSE
        drive(TIP, 3);
        check_eq("t2_level_qual", sync_level, 0);
        drive(IDLE, 5);
        check_eq("t2_level_after", sync_level, 0);
        check_eq("t2_queue_empty", q.size(), 0);

        // 3: single normal pulse, first start after reset reports no period
        pulse(10, 20);
        check_eq("t3_pulse_width", {16'd0, pulse_width}, 10);
        check_eq("t3_level_after", sync_level, 0);

        // 4: three pulses every 100 samples from a clean reset
        apply_reset(2);
        drive(IDLE, 5);
        for (int i = 0; i < 3; i++) pulse(10, 90);
        check_eq("t4_line_period", {16'd0, line_period}, 100);

        // 5: normal run then broad pulses
        for (int i = 0; i < 4; i++) pulse(10, 90);
        pulse(30, 70);
        check_eq("t5_broad_width", {16'd0, pulse_width}, 30);
        pulse(30, 70);
        check_eq("t5_broad_width2", {16'd0, pulse_width}, 30);

        // 6: hysteresis bounce inside a pulse
        base = samp;
        expect_start(base + MIN_P);
        push(K_HSYNC, base + 14 + MIN_P, 14);
        drive(TIP, 6);
        drive(IDLE, 2);
        drive(300, 1);
        check_eq("t6_level_bounce", sync_level, 1);
        drive(TIP, 5);
        drive(IDLE, 3);
        check_eq("t6_level_qual_high", sync_level, 1);
        drive(IDLE, 1);
        check_eq("t6_level_end", sync_level, 0);
        check_eq("t6_pulse_width", {16'd0, pulse_width}, 14);
        drive(IDLE, 20);

        check_eq("final_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
